rns_forward_converter: RTL

//  Binary-to-RNS forward converter; sits directly upstream of the RNS-to-binary converter.

---
 rtl/rns_forward_converter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rns_forward_converter.sv
// Iterative binary-to-RNS forward converter for the moduli {2^n-1, 2^n+1, 2^2n+1, 2^(2n+p)}.
// Consumes one n-bit chunk of X per cycle and keeps all three accumulators fully reduced.
module rns_forward_converter #(
  parameter int unsigned n = 20,
  parameter int unsigned p = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6*n+p-1:0]   X_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [n-1:0]       R1,
  output logic [n:0]         R2,
  output logic [2*n:0]       R3,
  output logic [2*n+p-1:0]   R4
);

  localparam int unsigned XW = 6*n + p;
  localparam int unsigned K  = (XW + n - 1) / n;
  localparam int unsigned KN = K * n;
  localparam int unsigned IW = $clog2(K);
  localparam int unsigned W2 = n + 3;
  localparam int unsigned W3 = 2*n + 3;

  localparam logic [W2-1:0] M2 = (W2'(1) << n) + W2'(1);
  localparam logic [W3-1:0] M3 = (W3'(1) << (2*n)) + W3'(1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state_q, state_d;
  logic [KN-1:0]     sr_q, sr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [n-1:0]      acc1_q, acc1_d;
  logic [n:0]        acc2_q, acc2_d;
  logic [2*n:0]      acc3_q, acc3_d;
  logic              in_ready_d, out_valid_d;
  logic [n-1:0]      r1_d;
  logic [n:0]        r2_d;
  logic [2*n:0]      r3_d;
  logic [2*n+p-1:0]  r4_d;

  logic [n-1:0]      chunk;
  logic [n:0]        s1;
  logic [n-1:0]      e1, a1_nxt;
  logic [W2-1:0]     s2p, s2m, a2;
  logic [n:0]        a2_nxt;
  logic [W3-1:0]     t3, s3p, s3m, a3;
  logic [2*n:0]      a3_nxt;

  // Per-chunk modular updates; chunk weights alternate sign mod m2 and follow a period-4 pattern mod m3
  always_comb begin
    chunk  = sr_q[n-1:0];
    s1     = {1'b0, acc1_q} + {1'b0, chunk};
    e1     = s1[n-1:0] + n'(s1[n]);
    a1_nxt = (e1 == {n{1'b1}}) ? '0 : e1;

    s2p = W2'(acc2_q) + W2'(chunk);
    s2m = W2'(acc2_q) - W2'(chunk);
    if (!idx_q[0]) a2 = (s2p >= M2) ? s2p - M2 : s2p;
    else           a2 = s2m[W2-1] ? s2m + M2 : s2m;
    a2_nxt = (n+1)'(a2);

    t3  = idx_q[0] ? (W3'(chunk) << n) : W3'(chunk);
    s3p = W3'(acc3_q) + t3;
    s3m = W3'(acc3_q) - t3;
    if (!idx_q[1]) a3 = (s3p >= M3) ? s3p - M3 : s3p;
    else           a3 = s3m[W3-1] ? s3m + M3 : s3m;
    a3_nxt = (2*n+1)'(a3);
  end

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    idx_d       = idx_q;
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    acc3_d      = acc3_q;
    out_valid_d = out_valid;
    r1_d        = R1;
    r2_d        = R2;
    r3_d        = R3;
    r4_d        = R4;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sr_d    = KN'(X_in);
          r4_d    = X_in[2*n+p-1:0];
          acc1_d  = '0;
          acc2_d  = '0;
          acc3_d  = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc1_d = a1_nxt;
        acc2_d = a2_nxt;
        acc3_d = a3_nxt;
        sr_d   = sr_q >> n;
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(K-1)) begin
          r1_d    = a1_nxt;
          r2_d    = a2_nxt;
          r3_d    = a3_nxt;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // out_valid trails entry into DONE by one cycle
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      idx_q     <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      acc3_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      R1        <= '0;
      R2        <= '0;
      R3        <= '0;
      R4        <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      idx_q     <= idx_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      acc3_q    <= acc3_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      R1        <= r1_d;
      R2        <= r2_d;
      R3        <= r3_d;
      R4        <= r4_d;
    end
  end

endmodule
